prescale_ctrl: RTL

Runtime-programmable controller for the sample-rate tick that paces the sine output path. It holds the divisor, starts and stops the tick stream, and counts ticks for finite bursts. Divisor changes made while running are applied only on a tick boundary, so the tick period never glitches. It replaces the fixed compile-time prescaler wherever the output frequency or sample count must change at runtime.

---
 rtl/prescale_ctrl_pkg.sv | 20 ++
 rtl/prescale_ctrl_core.sv | 27 ++
 rtl/prescale_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/prescale_ctrl_pkg.sv
// Shared types and constants for the runtime-programmable sample-rate prescaler.
package prescale_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Smallest period that still yields a one-cycle-high, one-cycle-low tick.
  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned SRC_CLK_HZ  = 100_000_000;
  localparam int unsigned OUT_FREQ_HZ = 48_000;

  // Divisor for a given source clock and target tick rate.
  function automatic int unsigned prescale_cnt(input int unsigned src_hz,
                                               input int unsigned out_hz);
    return src_hz / out_hz;
  endfunction

endpackage

// File: rtl/prescale_ctrl_core.sv
// Free-running period counter; flags the cycle in which it wraps back to zero.
module prescale_ctrl_core #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_src_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_wrap_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap   = i_en && (r_cnt >= (i_div - CNT_W'(1)));
  assign o_wrap_c = w_wrap;

  always_ff @(posedge i_src_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prescale_ctrl.sv
// Tick-stream controller: divisor/burst config with glitch-free commit on
// period boundaries, start/stop FSM, tick counting and burst completion.
module prescale_ctrl
  import prescale_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned BURST_W     = 16,
  parameter int unsigned DEFAULT_DIV = prescale_cnt(SRC_CLK_HZ, OUT_FREQ_HZ)
) (
  input  logic               i_src_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_div,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_busy,
  output logic               o_tick,
  output logic [BURST_W-1:0] o_tick_cnt,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DIV_RST =
      (DEFAULT_DIV < MIN_DIV) ? DIV_MIN : CNT_W'(DEFAULT_DIV);

  state_t             r_state,      w_state_nxt;
  logic [CNT_W-1:0]   r_div,        w_div_nxt;
  logic [BURST_W-1:0] r_burst,      w_burst_nxt;
  logic               r_pend_vld,   w_pend_vld_nxt;
  logic [CNT_W-1:0]   r_pend_div,   w_pend_div_nxt;
  logic [BURST_W-1:0] r_pend_burst, w_pend_burst_nxt;
  logic               r_cfg_ready,  w_cfg_ready_nxt;
  logic               r_tick,       w_tick_nxt;
  logic               r_done,       w_done_nxt;
  logic [BURST_W-1:0] r_tick_cnt,   w_tick_cnt_nxt;

  logic               w_accept;
  logic               w_wrap;
  logic               w_clr;
  logic               w_en;
  logic [CNT_W-1:0]   w_cfg_div_eff;
  logic [BURST_W-1:0] w_cnt_inc;
  logic [BURST_W-1:0] w_cnt_sat;

  assign w_accept      = i_cfg_valid && r_cfg_ready;
  assign w_cfg_div_eff = (i_cfg_div < DIV_MIN) ? DIV_MIN : i_cfg_div;
  assign w_cnt_inc     = r_tick_cnt + BURST_W'(1);
  assign w_cnt_sat     = (&r_tick_cnt) ? r_tick_cnt : w_cnt_inc;
  assign w_clr         = (r_state == ST_IDLE);
  assign w_en          = (r_state == ST_RUN);

  prescale_ctrl_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .i_src_clk (i_src_clk),
    .i_rst     (i_rst),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_div     (r_div),
    .o_wrap_c  (w_wrap)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_div_nxt        = r_div;
    w_burst_nxt      = r_burst;
    w_pend_vld_nxt   = r_pend_vld;
    w_pend_div_nxt   = r_pend_div;
    w_pend_burst_nxt = r_pend_burst;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_tick_nxt       = 1'b0;
    w_done_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_div_nxt   = w_cfg_div_eff;
          w_burst_nxt = i_cfg_burst;
        end
        if (i_start && !i_stop) begin
          w_state_nxt    = ST_RUN;
          w_tick_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        if (i_stop || r_done) begin
          // Leaving RUN: any held config becomes active immediately.
          w_state_nxt    = ST_IDLE;
          w_pend_vld_nxt = 1'b0;
          if (r_pend_vld) begin
            w_div_nxt   = r_pend_div;
            w_burst_nxt = r_pend_burst;
          end else if (w_accept) begin
            w_div_nxt   = w_cfg_div_eff;
            w_burst_nxt = i_cfg_burst;
          end
        end else begin
          if (w_wrap) begin
            w_tick_nxt     = 1'b1;
            w_tick_cnt_nxt = w_cnt_sat;
            if ((r_burst != '0) && (w_cnt_inc == r_burst)) begin
              w_done_nxt = 1'b1;
            end
            if (r_pend_vld) begin
              w_div_nxt      = r_pend_div;
              w_burst_nxt    = r_pend_burst;
              w_pend_vld_nxt = 1'b0;
            end
          end
          // An accept implies pending was empty, so it never races the commit.
          if (w_accept) begin
            w_pend_vld_nxt   = 1'b1;
            w_pend_div_nxt   = w_cfg_div_eff;
            w_pend_burst_nxt = i_cfg_burst;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_cfg_ready_nxt = (w_state_nxt == ST_IDLE) || !w_pend_vld_nxt;
  end

  always_ff @(posedge i_src_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_div        <= DIV_RST;
      r_burst      <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_div   <= '0;
      r_pend_burst <= '0;
      r_cfg_ready  <= 1'b1;
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
      r_tick_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_burst      <= w_burst_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_pend_burst <= w_pend_burst_nxt;
      r_cfg_ready  <= w_cfg_ready_nxt;
      r_tick       <= w_tick_nxt;
      r_done       <= w_done_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_busy      = (r_state == ST_RUN);
  assign o_tick      = r_tick;
  assign o_done      = r_done;
  assign o_tick_cnt  = r_tick_cnt;

endmodule
